// File: rtl/tohost_mailbox_pkg.sv
// Shared definitions for the tohost/fromhost mailbox: register map, status
// bit positions, handshake states and the byte-enable expansion helper.
package tohost_mailbox_pkg;

    localparam logic [4:0] ADDR_TOHOST   = 5'h00;
    localparam logic [4:0] ADDR_FROMHOST = 5'h08;
    localparam logic [4:0] ADDR_STATUS   = 5'h10;

    localparam int ST_TOHOST_VALID  = 0;
    localparam int ST_FROMHOST_FULL = 1;
    localparam int ST_TIMEOUT       = 2;
    localparam int ST_EXIT_VALID    = 3;

    typedef enum logic {
        IDLE,
        PENDING
    } state_t;

    function automatic logic [63:0] expand_wmask(input logic [7:0] wmask);
        logic [63:0] m;
        m = '0;
        for (int i = 0; i < 8; i++) begin
            m[i*8 +: 8] = {8{wmask[i]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/tohost_mailbox_if.sv
// Single-outstanding MMIO request/response bus between the core crossbar
// (master) and a 64-bit register endpoint (slave).
interface tohost_mailbox_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [4:0]  req_addr;
    logic [63:0] req_wdata;
    logic [7:0]  req_wmask;
    logic        resp_valid;
    logic [63:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_wmask,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_wmask,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/tohost_mailbox_watchdog.sv
// Saturating pending-cycle counter with a sticky, write-1-to-clear flag;
// the flag rises once the counter has spent TIMEOUT cycles running.
module mailbox_watchdog #(
    parameter int TIMEOUT = 50000,
    parameter int CNT_W   = 32
) (
    input  logic clock,
    input  logic reset_n,
    input  logic run,
    input  logic restart,
    input  logic clear,
    output logic flag
);
    localparam bit              ENABLE = (TIMEOUT != 0);
    localparam logic [CNT_W-1:0] LIMIT = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] count_reg, count_next;
    logic             flag_reg, flag_next;
    logic             hit;

    // Equality (not >=) so a cleared flag stays clear while the same stall persists.
    assign hit = ENABLE && run && (count_reg == LIMIT);

    always_comb begin
        count_next = count_reg;
        flag_next  = flag_reg;
        if (!run || restart) begin
            count_next = '0;
        end else if (count_reg != '1) begin
            count_next = count_reg + CNT_W'(1);
        end
        if (clear) flag_next = 1'b0;
        // A fresh expiry outranks a simultaneous clear so the event is not lost.
        if (hit) flag_next = 1'b1;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_reg <= '0;
            flag_reg  <= 1'b0;
        end else begin
            count_reg <= count_next;
            flag_reg  <= flag_next;
        end
    end

    assign flag = flag_reg;
endmodule

// File: rtl/tohost_mailbox.sv
// HTIF-style tohost/fromhost mailbox on a 64-bit MMIO slave port, with a
// sticky exit flag and a watchdog on the tohost pending handshake.
module tohost_mailbox
    import tohost_mailbox_pkg::*;
#(
    parameter int TIMEOUT = 50000,
    parameter int CNT_W   = 32
) (
    input  logic                    clock,
    input  logic                    reset_n,
    tohost_mailbox_if.slave         bus,
    output logic [63:0]             tohost,
    output logic                    tohost_valid,
    input  logic                    host_ack,
    input  logic                    fromhost_valid,
    output logic                    fromhost_ready,
    input  logic [63:0]             fromhost_data,
    output logic                    exit_valid,
    output logic [62:0]             exit_code,
    output logic                    timeout
);
    state_t      state_reg, state_next;
    logic [63:0] tohost_reg, tohost_next;
    logic [63:0] fromhost_reg, fromhost_next;
    logic        exit_valid_reg, exit_valid_next;
    logic [62:0] exit_code_reg, exit_code_next;
    logic        live_reg;
    logic        resp_valid_reg, resp_err_reg;
    logic [63:0] resp_rdata_reg;

    logic        hit_tohost, hit_fromhost, hit_status, addr_ok;
    logic        accept, tohost_stall, timeout_clear;
    logic [63:0] mask, merged_tohost, merged_fromhost, status_word, read_word;

    assign hit_tohost   = (bus.req_addr == ADDR_TOHOST);
    assign hit_fromhost = (bus.req_addr == ADDR_FROMHOST);
    assign hit_status   = (bus.req_addr == ADDR_STATUS);
    assign addr_ok      = hit_tohost || hit_fromhost || hit_status;

    // A second tohost post must wait until the host has consumed the first.
    assign tohost_stall  = (state_reg == PENDING) && bus.req_write && hit_tohost;
    assign bus.req_ready = live_reg && !resp_valid_reg && !tohost_stall;
    assign accept        = bus.req_valid && bus.req_ready;

    assign mask            = expand_wmask(bus.req_wmask);
    assign merged_tohost   = (tohost_reg & ~mask) | (bus.req_wdata & mask);
    assign merged_fromhost = (fromhost_reg & ~mask) | (bus.req_wdata & mask);
    assign timeout_clear   = accept && bus.req_write && hit_status &&
                             mask[ST_TIMEOUT] && bus.req_wdata[ST_TIMEOUT];

    always_comb begin
        status_word = '0;
        status_word[ST_TOHOST_VALID]  = tohost_valid;
        status_word[ST_FROMHOST_FULL] = !fromhost_ready;
        status_word[ST_TIMEOUT]       = timeout;
        status_word[ST_EXIT_VALID]    = exit_valid_reg;
    end

    always_comb begin
        read_word = '0;
        if (hit_tohost)        read_word = tohost_reg;
        else if (hit_fromhost) read_word = fromhost_reg;
        else if (hit_status)   read_word = status_word;
    end

    always_comb begin
        state_next      = state_reg;
        tohost_next     = tohost_reg;
        fromhost_next   = fromhost_reg;
        exit_valid_next = exit_valid_reg;
        exit_code_next  = exit_code_reg;
        case (state_reg)
            IDLE: begin
                if (accept && bus.req_write && hit_tohost) begin
                    tohost_next = merged_tohost;
                    if (merged_tohost != '0) state_next = PENDING;
                    if (merged_tohost[0]) begin
                        exit_valid_next = 1'b1;
                        exit_code_next  = merged_tohost[63:1];
                    end
                end
            end
            PENDING: begin
                if (host_ack) begin
                    tohost_next = '0;
                    state_next  = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        // Core writes win; a colliding host load is dropped and retried.
        if (accept && bus.req_write && hit_fromhost) begin
            fromhost_next = merged_fromhost;
        end else if (fromhost_valid && fromhost_ready) begin
            fromhost_next = fromhost_data;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= IDLE;
            tohost_reg     <= '0;
            fromhost_reg   <= '0;
            exit_valid_reg <= 1'b0;
            exit_code_reg  <= '0;
            live_reg       <= 1'b0;
            resp_valid_reg <= 1'b0;
            resp_err_reg   <= 1'b0;
            resp_rdata_reg <= '0;
        end else begin
            state_reg      <= state_next;
            tohost_reg     <= tohost_next;
            fromhost_reg   <= fromhost_next;
            exit_valid_reg <= exit_valid_next;
            exit_code_reg  <= exit_code_next;
            live_reg       <= 1'b1;
            resp_valid_reg <= accept;
            resp_err_reg   <= accept && !addr_ok;
            resp_rdata_reg <= (accept && !bus.req_write && addr_ok) ? read_word : '0;
        end
    end

    mailbox_watchdog #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_watchdog (
        .clock   (clock),
        .reset_n (reset_n),
        .run     (state_reg == PENDING),
        .restart (host_ack),
        .clear   (timeout_clear),
        .flag    (timeout)
    );

    assign bus.resp_valid = resp_valid_reg;
    assign bus.resp_rdata = resp_rdata_reg;
    assign bus.resp_err   = resp_err_reg;
    assign tohost         = tohost_reg;
    assign tohost_valid   = (state_reg == PENDING);
    assign fromhost_ready = (fromhost_reg == '0);
    assign exit_valid     = exit_valid_reg;
    assign exit_code      = exit_code_reg;
endmodule

// File: tb/tb_tohost_mailbox.sv
// Directed scenario bench for tohost_mailbox with TIMEOUT=8.
module tb_tohost_mailbox;
    import tohost_mailbox_pkg::*;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        host_ack = 1'b0;
    logic        fromhost_valid = 1'b0;
    logic [63:0] fromhost_data = '0;
    logic [63:0] tohost;
    logic        tohost_valid, fromhost_ready, exit_valid, timeout;
    logic [62:0] exit_code;
    int          checks = 0;
    int          passed = 0;

    tohost_mailbox_if bus();

    always #5 clock = ~clock;

    tohost_mailbox #(
        .TIMEOUT (8),
        .CNT_W   (32)
    ) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .bus            (bus),
        .tohost         (tohost),
        .tohost_valid   (tohost_valid),
        .host_ack       (host_ack),
        .fromhost_valid (fromhost_valid),
        .fromhost_ready (fromhost_ready),
        .fromhost_data  (fromhost_data),
        .exit_valid     (exit_valid),
        .exit_code      (exit_code),
        .timeout        (timeout)
    );

    // Issue one request, wait (bounded) for acceptance, return at the negedge of the response cycle.
    task automatic bus_xfer(input logic wr, input logic [4:0] addr, input logic [63:0] wdata,
                            input logic [7:0] wmask, output logic rv, output logic [63:0] rdata,
                            output logic err);
        int n = 0;
        @(posedge clock); #1;
        bus.req_valid = 1'b1;
        bus.req_write = wr;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        bus.req_wmask = wmask;
        @(negedge clock);
        while (bus.req_ready !== 1'b1 && n < 200) begin
            @(negedge clock);
            n++;
        end
        checks++;
        if (bus.req_ready !== 1'b1) begin
            $display("FAIL bus_accept addr=%02h got req_ready=%b required 1 within 200 cycles", addr, bus.req_ready);
            bus.req_valid = 1'b0;
            rv = 1'b0; rdata = '0; err = 1'b0;
            return;
        end
        passed++;
        @(posedge clock); #1;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        @(negedge clock);
        rv    = bus.resp_valid;
        rdata = bus.resp_rdata;
        err   = bus.resp_err;
        $display("xfer wr=%0b addr=%02h wdata=%016h wmask=%02h stall=%0d -> rv=%0b rdata=%016h err=%0b",
                 wr, addr, wdata, wmask, n, rv, rdata, err);
    endtask

    task automatic pulse_ack();
        @(posedge clock); #1; host_ack = 1'b1;
        @(posedge clock); #1; host_ack = 1'b0;
        @(negedge clock);
    endtask

    task automatic apply_reset();
        @(posedge clock); #1; reset_n = 1'b0;
        @(posedge clock); #1; reset_n = 1'b1;
        repeat (2) @(negedge clock);
    endtask

    task automatic test_reset();
        logic rv, err;
        logic [63:0] rd;
        reset_n = 1'b0;
        repeat (2) @(negedge clock);
        checks++; if (bus.req_ready !== 1'b0) $display("FAIL rst_req_ready got %b required 0", bus.req_ready); else passed++;
        checks++; if (bus.resp_valid !== 1'b0) $display("FAIL rst_resp_valid got %b required 0", bus.resp_valid); else passed++;
        checks++; if (tohost !== 64'h0) $display("FAIL rst_tohost got %h required 0", tohost); else passed++;
        checks++; if (fromhost_ready !== 1'b1) $display("FAIL rst_fromhost_ready got %b required 1", fromhost_ready); else passed++;
        checks++; if ({tohost_valid, exit_valid, timeout} !== 3'b000) $display("FAIL rst_flags got %b required 000", {tohost_valid, exit_valid, timeout}); else passed++;
        @(posedge clock); #1; reset_n = 1'b1;
        repeat (2) @(negedge clock);
        checks++; if (bus.req_ready !== 1'b1) $display("FAIL rst_ready_after got %b required 1", bus.req_ready); else passed++;
        bus_xfer(1'b1, ADDR_TOHOST, 64'h5, 8'hFF, rv, rd, err);
        checks++; if (tohost !== 64'h5 || tohost_valid !== 1'b1) $display("FAIL rst_post tohost=%h valid=%b required 5/1", tohost, tohost_valid); else passed++;
        checks++; if (exit_code !== 63'h2) $display("FAIL rst_exit_code got %h required 2", exit_code); else passed++;
        @(posedge clock); #1; reset_n = 1'b0;
        @(negedge clock);
        checks++; if (tohost !== 64'h0 || tohost_valid !== 1'b0) $display("FAIL rst_mid tohost=%h valid=%b required 0/0", tohost, tohost_valid); else passed++;
        checks++; if (timeout !== 1'b0 || fromhost_ready !== 1'b1) $display("FAIL rst_mid timeout=%b fh_ready=%b required 0/1", timeout, fromhost_ready); else passed++;
        checks++; if (exit_valid !== 1'b0 || exit_code !== 63'h0) $display("FAIL rst_mid_exit valid=%b code=%h required 0/0", exit_valid, exit_code); else passed++;
        @(posedge clock); #1; reset_n = 1'b1;
        repeat (2) @(negedge clock);
    endtask

    task automatic test_exit();
        logic rv, err;
        logic [63:0] rd;
        bus_xfer(1'b1, ADDR_TOHOST, 64'h1, 8'hFF, rv, rd, err);
        checks++; if (rv !== 1'b1) $display("FAIL exit_resp_valid got %b required 1", rv); else passed++;
        checks++; if (bus.req_ready !== 1'b0) $display("FAIL exit_ready_during_resp got %b required 0", bus.req_ready); else passed++;
        checks++; if (tohost_valid !== 1'b1 || exit_valid !== 1'b1) $display("FAIL exit_flags valid=%b exit=%b required 1/1", tohost_valid, exit_valid); else passed++;
        checks++; if (exit_code !== 63'h0) $display("FAIL exit_code got %h required 0", exit_code); else passed++;
        pulse_ack();
        checks++; if (tohost !== 64'h0 || tohost_valid !== 1'b0) $display("FAIL exit_ack tohost=%h valid=%b required 0/0", tohost, tohost_valid); else passed++;
        checks++; if (exit_valid !== 1'b1) $display("FAIL exit_sticky got %b required 1", exit_valid); else passed++;
        checks++; if (bus.resp_valid !== 1'b0) $display("FAIL exit_resp_pulse got %b required 0", bus.resp_valid); else passed++;
    endtask

    task automatic test_backpressure();
        logic rv, err;
        logic [63:0] rd;
        bus_xfer(1'b1, ADDR_TOHOST, 64'h80001000, 8'hFF, rv, rd, err);
        checks++; if (tohost !== 64'h80001000) $display("FAIL bp_first got %h required 80001000", tohost); else passed++;
        fork
            bus_xfer(1'b1, ADDR_TOHOST, 64'h42, 8'hFF, rv, rd, err);
            begin
                repeat (3) @(negedge clock);
                checks++; if (bus.req_ready !== 1'b0) $display("FAIL bp_stall got req_ready=%b required 0", bus.req_ready); else passed++;
                checks++; if (tohost !== 64'h80001000) $display("FAIL bp_hold got %h required 80001000", tohost); else passed++;
                @(posedge clock); #1; host_ack = 1'b1;
                @(posedge clock); #1; host_ack = 1'b0;
            end
        join
        checks++; if (tohost !== 64'h42 || tohost_valid !== 1'b1) $display("FAIL bp_second tohost=%h valid=%b required 42/1", tohost, tohost_valid); else passed++;
        pulse_ack();
        checks++; if (tohost_valid !== 1'b0) $display("FAIL bp_clear got %b required 0", tohost_valid); else passed++;
    endtask

    task automatic test_bytemask_err();
        logic rv, err;
        logic [63:0] rd;
        bus_xfer(1'b1, ADDR_TOHOST, 64'hAABB, 8'h01, rv, rd, err);
        checks++; if (tohost !== 64'hBB) $display("FAIL bm_merge got %h required bb", tohost); else passed++;
        checks++; if (exit_code !== 63'h5D) $display("FAIL bm_exit_code got %h required 5d", exit_code); else passed++;
        bus_xfer(1'b0, 5'h04, 64'h0, 8'hFF, rv, rd, err);
        checks++; if (rv !== 1'b1 || err !== 1'b1 || rd !== 64'h0) $display("FAIL bm_misaligned rv=%b err=%b rdata=%h required 1/1/0", rv, err, rd); else passed++;
        checks++; if (tohost !== 64'hBB) $display("FAIL bm_unchanged got %h required bb", tohost); else passed++;
        bus_xfer(1'b0, ADDR_TOHOST, 64'h0, 8'hFF, rv, rd, err);
        checks++; if (rd !== 64'hBB || err !== 1'b0) $display("FAIL bm_readback rdata=%h err=%b required bb/0", rd, err); else passed++;
        pulse_ack();
        pulse_ack();
        checks++; if (tohost !== 64'h0 || tohost_valid !== 1'b0) $display("FAIL bm_idle_ack tohost=%h valid=%b required 0/0", tohost, tohost_valid); else passed++;
        bus_xfer(1'b1, ADDR_TOHOST, 64'h0, 8'hFF, rv, rd, err);
        checks++; if (tohost_valid !== 1'b0) $display("FAIL bm_zero_post got valid=%b required 0", tohost_valid); else passed++;
        bus_xfer(1'b1, 5'h18, 64'hFFFF, 8'hFF, rv, rd, err);
        checks++; if (err !== 1'b1 || tohost !== 64'h0) $display("FAIL bm_unmapped err=%b tohost=%h required 1/0", err, tohost); else passed++;
    endtask

    task automatic test_timeout();
        logic rv, err;
        logic [63:0] rd;
        apply_reset();
        bus_xfer(1'b1, ADDR_TOHOST, 64'h10, 8'hFF, rv, rd, err);
        repeat (7) @(negedge clock);
        checks++; if (timeout !== 1'b0) $display("FAIL to_early got %b required 0 after 7 pending cycles", timeout); else passed++;
        @(negedge clock);
        checks++; if (timeout !== 1'b1) $display("FAIL to_fire got %b required 1 after 8 pending cycles", timeout); else passed++;
        bus_xfer(1'b0, ADDR_STATUS, 64'h0, 8'hFF, rv, rd, err);
        checks++; if (rd !== 64'h5) $display("FAIL to_status got %h required 5", rd); else passed++;
        bus_xfer(1'b1, ADDR_STATUS, 64'h3, 8'hFF, rv, rd, err);
        checks++; if (timeout !== 1'b1) $display("FAIL to_other_bits got %b required 1", timeout); else passed++;
        bus_xfer(1'b1, ADDR_STATUS, 64'h4, 8'hFF, rv, rd, err);
        checks++; if (timeout !== 1'b0) $display("FAIL to_w1c got %b required 0", timeout); else passed++;
        bus_xfer(1'b0, ADDR_STATUS, 64'h0, 8'hFF, rv, rd, err);
        checks++; if (rd !== 64'h1) $display("FAIL to_status_clr got %h required 1", rd); else passed++;
        pulse_ack();
        checks++; if (tohost_valid !== 1'b0 || timeout !== 1'b0) $display("FAIL to_ack valid=%b timeout=%b required 0/0", tohost_valid, timeout); else passed++;
    endtask

    task automatic test_fromhost_collision();
        logic rv, err;
        logic [63:0] rd;
        fork
            bus_xfer(1'b1, ADDR_FROMHOST, 64'h33, 8'hFF, rv, rd, err);
            begin
                @(posedge clock); #1;
                fromhost_valid = 1'b1;
                fromhost_data  = 64'h77;
            end
        join
        checks++; if (fromhost_ready !== 1'b0) $display("FAIL fh_ready_full got %b required 0", fromhost_ready); else passed++;
        bus_xfer(1'b0, ADDR_FROMHOST, 64'h0, 8'hFF, rv, rd, err);
        checks++; if (rd !== 64'h33) $display("FAIL fh_core_wins got %h required 33", rd); else passed++;
        bus_xfer(1'b0, ADDR_STATUS, 64'h0, 8'hFF, rv, rd, err);
        checks++; if (rd !== 64'h2) $display("FAIL fh_status got %h required 2", rd); else passed++;
        bus_xfer(1'b1, ADDR_FROMHOST, 64'h0, 8'hFF, rv, rd, err);
        checks++; if (fromhost_ready !== 1'b1) $display("FAIL fh_cleared got %b required 1", fromhost_ready); else passed++;
        @(posedge clock); #1; fromhost_valid = 1'b0;
        @(negedge clock);
        checks++; if (fromhost_ready !== 1'b0) $display("FAIL fh_retry_ready got %b required 0", fromhost_ready); else passed++;
        bus_xfer(1'b0, ADDR_FROMHOST, 64'h0, 8'hFF, rv, rd, err);
        checks++; if (rd !== 64'h77) $display("FAIL fh_retry_data got %h required 77", rd); else passed++;
    endtask

    initial begin
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.req_wmask = '0;
        test_reset();
        test_exit();
        test_backpressure();
        test_bytemask_err();
        test_timeout();
        test_fromhost_collision();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout simulation exceeded 200000 time units");
        $fatal(1);
    end
endmodule

// File: doc/tohost_mailbox.md
Name: tohost_mailbox

Overview:
- Synthesizable HTIF-style tohost/fromhost mailbox: the writer side of the tohost protocol that the simulation harness polls.
- Sits on the SoC MMIO crossbar as a 64-bit register slave. The core posts commands or the exit code into tohost. The host/harness consumes tohost, acknowledges it, and returns data via fromhost.
- Adds a pending-timeout watchdog and a sticky exit flag, so a stalled host handshake is visible to both sides.

Parameters:
- TIMEOUT, 50000, cycles tohost may stay pending before the timeout flag sets (0 disables).
- CNT_W, 32, width of the pending cycle counter (must hold TIMEOUT).

Ports:
- clock  in  1  single clock domain.
- reset_n  in  1  asynchronous assert, active-low. All state clears when low; deassert is sync to clock.
- req_valid  in  1  core MMIO request valid.
- req_ready  out  1  request accepted this cycle when req_valid&&req_ready.
- req_write  in  1  1=write, 0=read.
- req_addr  in  5  byte offset: 0x00 tohost, 0x08 fromhost, 0x10 status.
- req_wdata  in  64  write data.
- req_wmask  in  8  byte enables.
- resp_valid  out  1  one-cycle response pulse.
- resp_rdata  out  64  read data (0 for writes).
- resp_err  out  1  misaligned/unmapped address.
- tohost  out  64  current tohost register.
- tohost_valid  out  1  tohost nonzero and not yet acknowledged.
- host_ack  in  1  host consumed tohost.
- fromhost_valid  in  1  host offers fromhost_data.
- fromhost_ready  out  1  fromhost register is empty (==0).
- fromhost_data  in  64  host response word.
- exit_valid  out  1  sticky: a tohost with bit0=1 was posted.
- exit_code  out  63  tohost[63:1] captured at exit.
- timeout  out  1  sticky pending-timeout flag.

Behaviour:
- Reset (reset_n low, any time, including mid-handshake):
  - tohost=0, fromhost=0, FSM=IDLE, counter=0.
  - req_ready=0, resp_valid=0, resp_rdata=0, resp_err=0.
  - tohost_valid=0, fromhost_ready=1, exit_valid=0, exit_code=0, timeout=0.
- Request acceptance:
  - req_ready=1 in IDLE and PENDING, except a write to tohost while PENDING: req_ready=0 until host_ack is seen.
  - Exactly one response per accepted request, resp_valid the cycle after acceptance. No back-to-back pipelining; req_ready=0 while resp_valid=1.
- Address rules:
  - req_addr[2:0]!=0 or addr>0x10: resp_err=1, no state change, rdata=0.
- Writes: byte-masked merge, new = (old & ~M) | (wdata & M), where M expands wmask.
- Reads return the register value of the acceptance cycle.
- Status read layout: [0]=tohost_valid, [1]=!fromhost_ready, [2]=timeout, [3]=exit_valid, rest 0.
- Status write: bit2 write-1-to-clear timeout; other bits ignored.
- FSM IDLE -> PENDING: an accepted tohost write whose merged value is nonzero. tohost_valid=1 the cycle after acceptance.
  - A merged value of 0 stays IDLE.
  - Merged bit0=1 also sets exit_valid and latches exit_code the same cycle. exit_valid is cleared only by reset.
- PENDING -> IDLE: host_ack=1 clears tohost to 0 and tohost_valid=0 next cycle. host_ack in IDLE is ignored.
- Timeout counter:
  - Increments each PENDING cycle and saturates at all-ones; reset to 0 on leaving PENDING.
  - When it reaches TIMEOUT-1 while still PENDING, timeout sets the next cycle (so TIMEOUT pending cycles).
- fromhost:
  - fromhost_valid&&fromhost_ready latches fromhost_data. Data=0 is accepted but leaves fromhost_ready=1.
  - A core write to fromhost (masked merge) has priority over a host load in the same cycle; the host load is dropped and must retry since ready is re-evaluated.
  - The core clears fromhost by writing 0.
- Simultaneous events:
  - host_ack and a tohost write (stalled) in one cycle: ack wins, the write is accepted the following cycle.
  - host_ack and a timeout increment in one cycle: the counter resets and timeout does not set unless it reached TIMEOUT that cycle.

Decomposition:
- Shared package tohost_mailbox_pkg holds:
  - address constants ADDR_TOHOST=0x00, ADDR_FROMHOST=0x08, ADDR_STATUS=0x10;
  - status bit indices;
  - FSM enum {IDLE, PENDING};
  - the wmask-expansion function.
- One sub-module is natural: mailbox_watchdog (saturating counter plus sticky flag with W1C), reusable by other MMIO endpoints.

Test Plan:
- Reset/idle: assert reset_n low mid-PENDING with tohost=0x5 -> next cycle tohost=0, tohost_valid=0, timeout=0, fromhost_ready=1.
- Exit handshake: write tohost=0x1, wmask=0xFF -> resp_valid 1 cycle later, tohost_valid=1, exit_valid=1, exit_code=0. host_ack -> tohost=0 the next cycle, exit_valid stays 1.
- Backpressure: PENDING with tohost=0x80001000, second tohost write 0x42 -> req_ready=0 until host_ack. Then accepted, tohost=0x42 next cycle.
- Byte mask and error: tohost=0 IDLE, write 0xAABB with wmask=0x01 -> tohost=0xBB. Read at addr 0x04 -> resp_err=1, rdata=0, registers unchanged.
- Timeout: TIMEOUT=8, post tohost=0x10 with no ack -> timeout=1 after exactly 8 pending cycles, status read=0x5. Write status 0x4 -> timeout=0.
- fromhost collision: host offers 0x77 while the core writes fromhost=0x33 in the same cycle -> fromhost=0x33, fromhost_ready=0. Core writes 0 -> ready=1, host retry loads 0x77.
